// File: rtl/result_argmax.sv
// Scans the class-score result buffer after the final layer and reports the argmax class.
// Optional macro ARGMAX_SCORE_OUT_EN adds the max_score output carrying the winning score.
module result_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int LANES       = 5,
    parameter int DW          = 16,
    parameter int AW          = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [AW-1:0]           base_addr,
    output logic                    rd_en,
    output logic [AW-1:0]           rd_addr,
    input  logic [LANES*DW-1:0]     rd_data,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              class_idx,
`ifdef ARGMAX_SCORE_OUT_EN
    output logic signed [DW-1:0]    max_score,
`endif
    output logic                    result_valid
);

    localparam int WORDS = (NUM_CLASSES + LANES - 1) / LANES;
    localparam int CW    = (WORDS < 2) ? 1 : $clog2(WORDS);
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          rd_cnt;
    logic [CW-1:0]          word_p1;
    logic                   vld_p1;
    logic signed [DW-1:0]   max_p1;
    logic [3:0]             idx_p1;

    logic signed [DW-1:0]   lane_best;
    logic [3:0]             lane_idx;
    logic signed [DW-1:0]   merged_max;
    logic [3:0]             merged_idx;

    function automatic logic signed [DW-1:0] lane_score(input logic [LANES*DW-1:0] word,
                                                         input int k);
        return word[k*DW +: DW];
    endfunction

    // Stage p1: word returned by the buffer, reduced across lanes then merged with the running max.
    // Lanes are walked in index order with a strict compare so the lowest index wins ties.
    always_comb begin
        int gidx;
        lane_best = lane_score(rd_data, 0);
        lane_idx  = 4'(int'(word_p1) * LANES);
        for (int k = 1; k < LANES; k++) begin
            gidx = int'(word_p1) * LANES + k;
            if (gidx < NUM_CLASSES && lane_score(rd_data, k) > lane_best) begin
                lane_best = lane_score(rd_data, k);
                lane_idx  = 4'(gidx);
            end
        end
        merged_max = max_p1;
        merged_idx = idx_p1;
        if (word_p1 == '0 || lane_best > max_p1) begin
            merged_max = lane_best;
            merged_idx = lane_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            class_idx    <= '0;
            result_valid <= 1'b0;
            rd_cnt       <= '0;
            word_p1      <= '0;
            vld_p1       <= 1'b0;
            max_p1       <= '0;
            idx_p1       <= '0;
`ifdef ARGMAX_SCORE_OUT_EN
            max_score    <= '0;
`endif
        end else begin
            vld_p1 <= rd_en;
            done   <= 1'b0;
            if (vld_p1) begin
                max_p1 <= merged_max;
                idx_p1 <= merged_idx;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= READ;
                        rd_en        <= 1'b1;
                        rd_addr      <= base_addr;
                        rd_cnt       <= '0;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                    end
                end
                // Stage p0: one read per cycle; the address wraps naturally at 2^AW.
                READ: begin
                    word_p1 <= rd_cnt;
                    if (rd_cnt == LAST_WORD) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_cnt  <= rd_cnt + CW'(1);
                        rd_addr <= rd_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    class_idx    <= merged_idx;
`ifdef ARGMAX_SCORE_OUT_EN
                    max_score    <= merged_max;
`endif
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_argmax.sv
// Directed bench for result_argmax: a buffer model feeds scores, a scoreboard checks reads and results.
module tb_result_argmax;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [79:0] rd_data = '0;
    logic        busy, done, result_valid;
    logic [3:0]  class_idx;

    logic        start7 = 1'b0;
    logic [3:0]  base7 = '0;
    logic        rd_en7;
    logic [3:0]  rd_addr7;
    logic [79:0] rd_data7 = '0;
    logic        busy7, done7, result_valid7;
    logic [3:0]  class_idx7;
`ifdef ARGMAX_SCORE_OUT_EN
    logic signed [15:0] max_score, max_score7;
`endif

    logic [79:0] mem [16];
    int cyc = 0;
    int start_cyc = 0;
    int checks = 0;
    int errors = 0;
    int reads7 = 0;

    typedef struct { logic [3:0] idx; logic [15:0] score; } res_t;
    res_t        exp_res [$];
    logic [3:0]  exp_addr [$];

    result_argmax dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .class_idx(class_idx),
`ifdef ARGMAX_SCORE_OUT_EN
        .max_score(max_score),
`endif
        .result_valid(result_valid)
    );

    result_argmax #(.NUM_CLASSES(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .start(start7), .base_addr(base7),
        .rd_en(rd_en7), .rd_addr(rd_addr7), .rd_data(rd_data7),
        .busy(busy7), .done(done7), .class_idx(class_idx7),
`ifdef ARGMAX_SCORE_OUT_EN
        .max_score(max_score7),
`endif
        .result_valid(result_valid7)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: one-cycle read latency, junk on the bus when no read was issued.
    always @(posedge clk) begin
        rd_data  <= rd_en  ? mem[rd_addr]  : 80'({$urandom(), $urandom(), $urandom()});
        rd_data7 <= rd_en7 ? mem[rd_addr7] : 80'({$urandom(), $urandom(), $urandom()});
        if (rd_en7) reads7 <= reads7 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] pack(input int s0, input int s1, input int s2,
                                         input int s3, input int s4);
        return {16'(s4), 16'(s3), 16'(s2), 16'(s1), 16'(s0)};
    endfunction

    always @(negedge clk) begin
        if (rd_en) begin
            if (exp_addr.size() == 0) chk("unexpected_read", 32'(rd_addr), 32'hFFFF);
            else chk("rd_addr", 32'(rd_addr), 32'(exp_addr.pop_front()));
        end
    end

    always @(negedge clk) begin
        res_t r;
        if (done) begin
            chk("done_latency", 32'(cyc - start_cyc), 32'd4);
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("valid_at_done", 32'(result_valid), 32'd1);
            if (exp_res.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                r = exp_res.pop_front();
                chk("class_idx", 32'(class_idx), 32'(r.idx));
`ifdef ARGMAX_SCORE_OUT_EN
                chk("max_score", 32'(max_score), 32'(r.score));
`endif
            end
        end
    end

    task automatic push_scan(input logic [3:0] base, input logic [3:0] idx, input int score);
        res_t r;
        r.idx = idx;
        r.score = 16'(score);
        exp_addr.push_back(base);
        exp_addr.push_back(base + 4'd1);
        exp_res.push_back(r);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic run_scan(input logic [3:0] base, input logic [3:0] idx, input int score);
        @(posedge clk); #1;
        push_scan(base, idx, score);
        base_addr = base;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_cycle1", 32'(busy), 32'd1);
        chk("valid_drops", 32'(result_valid), 32'd0);
        wait_done();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0]  = pack(4, -3, 9, 1, 0);
        mem[1]  = pack(2, 8, -1, 7, 5);
        mem[2]  = pack(-32768, -32768, -32768, -5, -32768);
        mem[3]  = pack(-32768, -32768, -5, -32768, -32768);
        mem[4]  = pack(1, 2, 3, -4, 99);
        mem[5]  = pack(50, 100, 32767, 32767, 32767);
        mem[15] = pack(10, 20, -30, 40, 500);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_class_idx", 32'(class_idx), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        rst_n = 1'b1;

        // Basic scan from address 0.
        run_scan(4'd0, 4'd2, 9);
        chk("valid_held", 32'(result_valid), 32'd1);

        // Ties resolve to the lowest index, negatives compare signed.
        run_scan(4'd2, 4'd3, -5);

        // Address wrap from 15 to 0; class 8 ties class 6 and loses.
        mem[0] = pack(999, 1000, 3, 1000, -1000);
        run_scan(4'd15, 4'd6, 1000);
        mem[0] = pack(4, -3, 9, 1, 0);

        // Second start in cycle 2 ignored, then back-to-back scan one cycle after done.
        @(posedge clk); #1;
        push_scan(4'd0, 4'd2, 9);
        base_addr = 4'd0;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("held_idx_during_scan", 32'(class_idx), 32'd6);
        @(posedge clk); #1;
        base_addr = 4'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        push_scan(4'd2, 4'd3, -5);
        base_addr = 4'd2;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_valid_drops", 32'(result_valid), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done();
        chk("b2b_valid_rises", 32'(result_valid), 32'd1);

        // Reset asserted in cycle 2 of a scan.
        @(posedge clk); #1;
        push_scan(4'd0, 4'd2, 9);
        base_addr = 4'd0;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_addr.delete();
        exp_res.delete();
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_valid", 32'(result_valid), 32'd0);
        chk("mid_rst_class_idx", 32'(class_idx), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_scan(4'd0, 4'd2, 9);

        // Padding lanes beyond NUM_CLASSES=7 hold 0x7FFF and must be ignored.
        @(posedge clk); #1;
        base7 = 4'd4;
        start7 = 1'b1;
        @(posedge clk); #1;
        start7 = 1'b0;
        n = 0;
        while (!done7 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pad_done_latency", 32'(n), 32'd3);
        chk("pad_class_idx", 32'(class_idx7), 32'd6);
        chk("pad_valid", 32'(result_valid7), 32'd1);
        chk("pad_reads", 32'(reads7), 32'd2);
`ifdef ARGMAX_SCORE_OUT_EN
        chk("pad_max_score", 32'(max_score7), 32'd100);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("leftover_reads", 32'(exp_addr.size()), 32'd0);
        chk("leftover_results", 32'(exp_res.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
